seq_comb_monitor: RTL and testbench
===================================

Name: seq_comb_monitor

Overview:
- Clocked observer for scheduling/propagation examples: watches a driven signal and N copies of it produced by different paths (continuous assign, always_comb, gate primitives).
- After each change of the driven value, waits a fixed settle window, then checks that every path copy equals the driven value.
- Reports per-path mismatches and keeps a saturating error count.
- Sits at the observing end of the stimulus driver, in place of ad-hoc $display checks.

Parameters:
- N_PATHS, 4, number of observed path copies (>=1)
- SETTLE_CYCLES, 2, cycles spent in SETTLE before the compare (>=1)
- CNT_W, 8, width of err_cnt

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- en  input  1  monitor enable
- drv  input  1  driven source value
- obs  input  N_PATHS  path copies of drv; bit i = path i
- err_clr  input  1  clears err_cnt
- chk_valid  output  1  one-cycle pulse: a check completed
- chk_pass  output  1  result of last check (1 = all paths agree)
- mismatch_mask  output  N_PATHS  bit i set = path i disagreed at last check
- err_cnt  output  CNT_W  number of failed checks, saturating
- busy  output  1  state != IDLE

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, drv_q=0, settle counter=0.
  - chk_valid=0, chk_pass=0, mismatch_mask=0, err_cnt=0, busy=0.
  - rst overrides every other input.
- drv_q is a register that samples drv every cycle, regardless of en.
- change = en & (drv != drv_q), evaluated combinationally in the current cycle.
  - A drv of 1 in the first cycle after reset therefore counts as a change.
- States:
  - IDLE: if change, go to SETTLE with cnt=0; otherwise stay.
  - SETTLE:
    - If en=0, abort to IDLE; no check, no outputs updated.
    - Else if change, stay in SETTLE and reset cnt=0 (retrigger; change has priority over completing the window).
    - Else if cnt == SETTLE_CYCLES-1, perform the compare at this edge and go to IDLE.
    - Else cnt=cnt+1.
- Compare, at the final SETTLE edge, against drv_q:
  - mismatch_mask <= obs ^ {N_PATHS{drv_q}}.
  - chk_pass <= (mismatch == 0).
  - chk_valid <= 1 for exactly the next cycle.
  - err_cnt increments by 1 per failed check, not per failing bit.
- Latency: a change in cycle t with no further change gives chk_valid high in cycle t+SETTLE_CYCLES+1.
- Back-to-back: a change in the cycle chk_valid is high is accepted normally (IDLE -> SETTLE).
- chk_pass and mismatch_mask hold until the next check.
- err_cnt:
  - Saturates at 2^CNT_W-1 and does not wrap.
  - err_clr sets it to 0 at the next edge.
  - err_clr coincident with a failing check: clear wins, result is 0. chk_pass and mismatch_mask are still updated.
- busy is combinational from state.
- obs is sampled only at the compare edge; glitches during SETTLE are ignored.

Test Plan (N_PATHS=4, SETTLE_CYCLES=2, CNT_W=8):
- Reset, then drv 0->1 in cycle t with obs=4'b1111 from t+1 -> chk_valid only in cycle t+3, chk_pass=1, mismatch_mask=0, err_cnt=0.
- drv 1->0 with obs held at 4'b0100 -> chk_pass=0, mismatch_mask=4'b0100, err_cnt=1; mask holds until the next check.
- drv toggles at t and again at t+2 -> no chk_valid at t+3; a single chk_valid at t+5, comparing against the final drv value.
- en dropped to 0 during SETTLE -> busy=0 next cycle, no chk_valid, outputs unchanged; drv toggling while en=0 -> no activity.
- 256 consecutive failing checks -> err_cnt=255 and stays there; err_clr pulsed in a failing check's compare cycle -> err_cnt=0, chk_pass=0.
- rst asserted mid-SETTLE -> next cycle all outputs 0, state IDLE; with drv=1 held after reset -> one check completes, chk_valid 3 cycles after rst deasserts.

Source files
------------

// File: rtl/seq_comb_monitor.sv
// seq_comb_monitor: clocked observer that watches a driven signal and several
// copies of it produced by different propagation paths.  After every change of
// the driven value it waits a fixed settle window, then compares each path copy
// against the registered driven value.  It reports a per-path mismatch mask,
// a pass/fail flag and a saturating count of failed checks.
`timescale 1ns/1ps

module seq_comb_monitor #(
    parameter int N_PATHS       = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               drv,
    input  logic [N_PATHS-1:0] obs,
    input  logic               err_clr,
    output logic               chk_valid,
    output logic               chk_pass,
    output logic [N_PATHS-1:0] mismatch_mask,
    output logic [CNT_W-1:0]   err_cnt,
    output logic               busy
);

    // The settle counter only has to reach SETTLE_CYCLES-1; a window of one
    // cycle still gets a one-bit counter so the vector is never zero-width.
    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic          drv_q;
    logic          change;
    logic          do_compare;
    logic [N_PATHS-1:0] mismatch;

    // A change is any difference between the live drive and last cycle's
    // sample while monitoring is enabled; it is evaluated in the same cycle.
    assign change = en & (drv != drv_q);

    // Per-path disagreement against the registered drive value.
    assign mismatch = obs ^ {N_PATHS{drv_q}};

    // busy simply reflects that a settle window is in progress.
    assign busy = (state != IDLE);

    // drv_q follows drv every cycle, independent of en, so re-enabling never
    // sees a stale value as a change.
    always_ff @(posedge clk) begin
        if (rst) begin
            drv_q <= 1'b0;
        end else begin
            drv_q <= drv;
        end
    end

    // State and settle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state logic: disabling aborts, a new change retriggers the window,
    // and only an undisturbed full window ends in a compare.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        do_compare = 1'b0;
        unique case (state)
            IDLE: begin
                if (change) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end
            SETTLE: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (change) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    do_compare = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Check result registers: the valid pulse lasts one cycle, while the pass
    // flag and mismatch mask hold until the next completed check.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_valid     <= 1'b0;
            chk_pass      <= 1'b0;
            mismatch_mask <= '0;
        end else begin
            chk_valid <= do_compare;
            if (do_compare) begin
                chk_pass      <= (mismatch == '0);
                mismatch_mask <= mismatch;
            end
        end
    end

    // Failed-check counter: counts checks rather than failing bits, sticks at
    // its maximum, and an explicit clear beats a coincident failure.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (do_compare && (mismatch != '0) && (err_cnt != ERR_MAX)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_comb_monitor.sv
// tb_seq_comb_monitor: directed bench for seq_comb_monitor.  A cycle-stamped
// reference model predicts every output each cycle; literal expectations at
// key points pin the model against hand-computed values.
`timescale 1ns/1ps

module tb_seq_comb_monitor;

    localparam int N_PATHS       = 4;
    localparam int SETTLE_CYCLES = 2;
    localparam int CNT_W         = 8;
    localparam int ERR_MAX       = (1 << CNT_W) - 1;

    logic               clk;
    logic               rst;
    logic               en;
    logic               drv;
    logic [N_PATHS-1:0] obs;
    logic               err_clr;
    logic               chk_valid;
    logic               chk_pass;
    logic [N_PATHS-1:0] mismatch_mask;
    logic [CNT_W-1:0]   err_cnt;
    logic               busy;

    int checks;
    int errors;

    seq_comb_monitor #(
        .N_PATHS       (N_PATHS),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .drv           (drv),
        .obs           (obs),
        .err_clr       (err_clr),
        .chk_valid     (chk_valid),
        .chk_pass      (chk_pass),
        .mismatch_mask (mismatch_mask),
        .err_cnt       (err_cnt),
        .busy          (busy)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: remembers the cycle of the most recent accepted change
    // and fires a compare exactly SETTLE_CYCLES cycles later if nothing
    // intervened.
    int        cycle_no;
    int        change_cycle;
    bit        armed;
    bit        prev_drv;
    bit        model_ready;
    bit        exp_valid;
    bit        exp_pass;
    bit [N_PATHS-1:0] exp_mask;
    int        exp_err;

    always @(posedge clk) begin
        bit fire;
        fire = 1'b0;
        cycle_no = cycle_no + 1;
        if (rst) begin
            armed       = 1'b0;
            prev_drv    = 1'b0;
            exp_valid   = 1'b0;
            exp_pass    = 1'b0;
            exp_mask    = '0;
            exp_err     = 0;
            model_ready = 1'b1;
        end else begin
            if (!en) begin
                armed = 1'b0;
            end else if (drv != prev_drv) begin
                armed        = 1'b1;
                change_cycle = cycle_no;
            end else if (armed && (cycle_no == change_cycle + SETTLE_CYCLES)) begin
                fire  = 1'b1;
                armed = 1'b0;
            end
            if (fire) begin
                for (int i = 0; i < N_PATHS; i++) begin
                    exp_mask[i] = (obs[i] != prev_drv);
                end
                exp_pass = (exp_mask == '0);
                if (!exp_pass) begin
                    exp_err = (exp_err + 1 > ERR_MAX) ? ERR_MAX : exp_err + 1;
                end
            end
            if (err_clr) begin
                exp_err = 0;
            end
            exp_valid = fire;
            prev_drv  = drv;
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (model_ready) begin
            checks = checks + 5;
            if (chk_valid !== exp_valid) begin
                errors = errors + 1;
                $display("[TB] FAIL model chk_valid cycle %0d: got %b want %b", cycle_no, chk_valid, exp_valid);
            end
            if (chk_pass !== exp_pass) begin
                errors = errors + 1;
                $display("[TB] FAIL model chk_pass cycle %0d: got %b want %b", cycle_no, chk_pass, exp_pass);
            end
            if (mismatch_mask !== exp_mask) begin
                errors = errors + 1;
                $display("[TB] FAIL model mismatch_mask cycle %0d: got %b want %b", cycle_no, mismatch_mask, exp_mask);
            end
            if (err_cnt !== CNT_W'(exp_err)) begin
                errors = errors + 1;
                $display("[TB] FAIL model err_cnt cycle %0d: got %0d want %0d", cycle_no, err_cnt, exp_err);
            end
            if (busy !== armed) begin
                errors = errors + 1;
                $display("[TB] FAIL model busy cycle %0d: got %b want %b", cycle_no, busy, armed);
            end
        end
    end

    // Advance n clock edges, landing just after the last rising edge.
    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Literal expectation check.
    task automatic check_output(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d want %0d", name, actual, expected);
        end
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Directed scenario sequence.
    initial begin
        checks       = 0;
        errors       = 0;
        cycle_no     = 0;
        change_cycle = 0;
        armed        = 1'b0;
        prev_drv     = 1'b0;
        model_ready  = 1'b0;
        exp_valid    = 1'b0;
        exp_pass     = 1'b0;
        exp_mask     = '0;
        exp_err      = 0;

        rst     = 1'b1;
        en      = 1'b0;
        drv     = 1'b0;
        obs     = '0;
        err_clr = 1'b0;
        apply_stimulus(2);
        check_output("reset chk_valid", int'(chk_valid), 0);
        check_output("reset busy", int'(busy), 0);
        check_output("reset err_cnt", int'(err_cnt), 0);
        check_output("reset mask", int'(mismatch_mask), 0);

        rst = 1'b0;
        en  = 1'b1;
        apply_stimulus(2);

        // Clean 0->1 with all paths following.
        $display("[TB] rising edge, all paths agree");
        drv = 1'b1;
        apply_stimulus(1);
        obs = 4'b1111;
        check_output("t1 busy", int'(busy), 1);
        check_output("t1 valid early t+1", int'(chk_valid), 0);
        apply_stimulus(1);
        check_output("t1 valid early t+2", int'(chk_valid), 0);
        apply_stimulus(1);
        check_output("t1 valid t+3", int'(chk_valid), 1);
        check_output("t1 pass", int'(chk_pass), 1);
        check_output("t1 mask", int'(mismatch_mask), 0);
        check_output("t1 err_cnt", int'(err_cnt), 0);
        apply_stimulus(1);
        check_output("t1 valid drop", int'(chk_valid), 0);

        // 1->0 with path 2 stuck high.
        $display("[TB] falling edge, path 2 stuck");
        drv = 1'b0;
        obs = 4'b0100;
        apply_stimulus(3);
        check_output("t2 valid", int'(chk_valid), 1);
        check_output("t2 pass", int'(chk_pass), 0);
        check_output("t2 mask", int'(mismatch_mask), 4);
        check_output("t2 err_cnt", int'(err_cnt), 1);
        apply_stimulus(2);
        check_output("t2 mask hold", int'(mismatch_mask), 4);

        // Retrigger inside the window.
        $display("[TB] retrigger");
        drv = 1'b1;
        obs = 4'b1111;
        apply_stimulus(2);
        drv = 1'b0;
        obs = 4'b0000;
        apply_stimulus(1);
        check_output("t3 no valid t+3", int'(chk_valid), 0);
        check_output("t3 busy t+3", int'(busy), 1);
        apply_stimulus(2);
        check_output("t3 valid t+5", int'(chk_valid), 1);
        check_output("t3 pass", int'(chk_pass), 1);

        // Abort by dropping en, then toggle while disabled.
        $display("[TB] enable abort");
        drv = 1'b1;
        apply_stimulus(1);
        en = 1'b0;
        apply_stimulus(1);
        check_output("t4 busy after abort", int'(busy), 0);
        drv = 1'b0;
        apply_stimulus(1);
        drv = 1'b1;
        apply_stimulus(1);
        check_output("t4 valid while disabled", int'(chk_valid), 0);
        check_output("t4 err_cnt unchanged", int'(err_cnt), 1);
        en = 1'b1;
        apply_stimulus(3);
        check_output("t4 idle after reenable", int'(busy), 0);

        // Back-to-back failing checks until the counter saturates.
        $display("[TB] saturation");
        for (int i = 0; i < 256; i++) begin
            drv = ~drv;
            obs = drv ? 4'b0000 : 4'b1111;
            apply_stimulus(3);
        end
        check_output("t5 saturated", int'(err_cnt), 255);
        check_output("t5 valid last", int'(chk_valid), 1);

        // Clear coincident with a failing compare.
        drv = ~drv;
        obs = drv ? 4'b0000 : 4'b1111;
        apply_stimulus(2);
        err_clr = 1'b1;
        apply_stimulus(1);
        err_clr = 1'b0;
        check_output("t5 clear wins", int'(err_cnt), 0);
        check_output("t5 clear pass", int'(chk_pass), 0);
        check_output("t5 clear valid", int'(chk_valid), 1);
        check_output("t5 clear mask", int'(mismatch_mask), 15);

        // Reset in the middle of a settle window.
        $display("[TB] reset mid-settle");
        obs = 4'b0000;
        drv = ~drv;
        apply_stimulus(1);
        check_output("t6 busy before rst", int'(busy), 1);
        rst = 1'b1;
        drv = 1'b1;
        obs = 4'b1111;
        apply_stimulus(1);
        check_output("t6 rst busy", int'(busy), 0);
        check_output("t6 rst mask", int'(mismatch_mask), 0);
        check_output("t6 rst valid", int'(chk_valid), 0);
        rst = 1'b0;
        apply_stimulus(3);
        check_output("t6 valid after rst", int'(chk_valid), 1);
        check_output("t6 pass after rst", int'(chk_pass), 1);
        apply_stimulus(1);
        check_output("t6 valid drop", int'(chk_valid), 0);
        apply_stimulus(3);
        check_output("t6 single check", int'(chk_valid), 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
